// File: rtl/data_path_mc_if.sv
// Instruction handshake and memory request/acknowledge bus for data_path_mc.
// master = datapath side, slave = fetch/memory side.
interface data_path_mc_if #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  instr_valid, instr, mem_rdata, mem_ack,
    output instr_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    output instr_valid, instr, mem_rdata, mem_ack,
    input  instr_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/data_path_mc.sv
// Multi-cycle datapath: IDLE -> EXEC -> (MEM) -> WB, 8-entry register file.
// Optional overflow trap enabled by defining DATA_PATH_MC_OVF_TRAP_EN.
module data_path_mc #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  data_path_mc_if.master    bus,
  output logic [DATA_W-1:0] out,
  output logic              done,
  output logic              redirect_valid,
  output logic [PC_W-1:0]   redirect_target,
  output logic              zero_flag,
  output logic              neg_flag,
`ifdef DATA_PATH_MC_OVF_TRAP_EN
  output logic              ovf_flag,
  output logic              trap
`else
  output logic              ovf_flag
`endif
);
  localparam int M = DATA_W - 1;

  typedef enum logic [1:0] {IDLE, EXEC, MEM, WB} state_t;
  state_t state;

  logic [15:0]             ir;
  logic [7:0][DATA_W-1:0]  rf;
  logic                    rdy, mem_req_q, mem_we_q;
  logic [MEM_AW-1:0]       mem_addr_q;
  logic [DATA_W-1:0]       mem_wdata_q, res;
  logic                    we_r, flag_r, out_r, ovf_r;
  logic [PC_W-1:0]         tgt_r;

  logic [3:0] op;
  logic [2:0] rd_a, rs1_a, rs2_a, shamt;
  logic [5:0] imm;
  logic [8:0] jt;
  assign op    = ir[3:0];
  assign rd_a  = ir[6:4];
  assign rs1_a = ir[9:7];
  assign rs2_a = ir[12:10];
  assign imm   = ir[15:10];
  assign shamt = ir[15:13];
  assign jt    = ir[12:4];

  logic [DATA_W-1:0] a, b, d, immz, x_res;
  logic              x_ovf, x_we, x_flag, x_out, x_br, x_mem;
  logic [PC_W-1:0]   x_tgt;
  logic [MEM_AW-1:0] x_addr;

  always_comb begin
    a      = rf[rs1_a];
    b      = rf[rs2_a];
    d      = rf[rd_a];
    immz   = DATA_W'(imm);
    x_res  = '0;
    x_ovf  = 1'b0;
    x_out  = 1'b1;
    x_br   = 1'b0;
    x_tgt  = PC_W'(imm);
    x_mem  = 1'b0;
    x_addr = MEM_AW'(a + immz);
    case (op)
      4'd0: begin x_res = a + b; x_ovf = (a[M] == b[M]) && (x_res[M] != a[M]); end
      4'd1: x_res = a << shamt;
      4'd2: x_res = a >> shamt;
      4'd3: begin x_res = a - b; x_ovf = (a[M] != b[M]) && (x_res[M] != a[M]); end
      4'd4: x_res = a & b;
      4'd5: x_res = a | b;
      4'd6: x_res = immz;
      4'd7: x_mem = 1'b1;
      4'd8: begin x_mem = 1'b1; x_res = d; end
      4'd9: begin x_res = a + immz; x_ovf = (a[M] == immz[M]) && (x_res[M] != a[M]); end
      4'd10: begin x_res = d; x_br = (d == '0); end
      4'd11: begin x_res = d - a; x_br = (d == a); end
      // jump has nothing to compare, so it reports a zero difference
      4'd12: begin x_br = 1'b1; x_tgt = PC_W'(jt); end
      default: x_out = 1'b0;
    endcase
    x_flag = (op <= 4'd6) || (op == 4'd9);
    x_we   = x_flag || (op == 4'd7);
`ifdef DATA_PATH_MC_OVF_TRAP_EN
    if (x_ovf) x_we = 1'b0;
`endif
  end

  assign bus.instr_ready = rdy;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      ir              <= '0;
      rf              <= '0;
      rdy             <= 1'b0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      res             <= '0;
      we_r            <= 1'b0;
      flag_r          <= 1'b0;
      out_r           <= 1'b0;
      ovf_r           <= 1'b0;
      tgt_r           <= '0;
      out             <= '0;
      done            <= 1'b0;
      redirect_valid  <= 1'b0;
      redirect_target <= '0;
      zero_flag       <= 1'b0;
      neg_flag        <= 1'b0;
      ovf_flag        <= 1'b0;
`ifdef DATA_PATH_MC_OVF_TRAP_EN
      trap            <= 1'b0;
`endif
    end else begin
      done           <= 1'b0;
      redirect_valid <= 1'b0;
`ifdef DATA_PATH_MC_OVF_TRAP_EN
      trap           <= 1'b0;
`endif
      case (state)
        IDLE: begin
          rdy <= 1'b1;
          if (rdy && bus.instr_valid) begin
            ir    <= bus.instr;
            rdy   <= 1'b0;
            state <= EXEC;
          end
        end
        EXEC: begin
          res    <= x_res;
          we_r   <= x_we;
          flag_r <= x_flag;
          out_r  <= x_out;
          ovf_r  <= x_ovf;
          tgt_r  <= x_tgt;
          if (x_mem) begin
            state       <= MEM;
            mem_req_q   <= 1'b1;
            mem_we_q    <= (op == 4'd8);
            mem_addr_q  <= x_addr;
            mem_wdata_q <= d;
          end else begin
            state          <= WB;
            done           <= 1'b1;
            redirect_valid <= x_br;
`ifdef DATA_PATH_MC_OVF_TRAP_EN
            trap           <= x_ovf;
`endif
          end
        end
        MEM: begin
          // request fields stay frozen until the memory acknowledges
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            if (op == 4'd7) res <= bus.mem_rdata;
            state <= WB;
            done  <= 1'b1;
          end
        end
        WB: begin
          if (we_r)           rf[rd_a] <= res;
          if (out_r)          out <= res;
          if (redirect_valid) redirect_target <= tgt_r;
          if (flag_r) begin
            zero_flag <= (res == '0);
            neg_flag  <= res[M];
            ovf_flag  <= ovf_r;
          end
          rdy   <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_path_mc.sv
// Scoreboard bench for data_path_mc: directed instructions push expectations,
// a monitor pops them on every done pulse; a small memory model answers requests.
module tb_data_path_mc;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

`ifdef DATA_PATH_MC_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  data_path_mc_if #(.DATA_W(16), .MEM_AW(8)) bus();
  logic [15:0] out;
  logic        done, redirect_valid, zero_flag, neg_flag, ovf_flag;
  logic [7:0]  redirect_target;
`ifdef DATA_PATH_MC_OVF_TRAP_EN
  logic        trap;
`endif

  data_path_mc #(.DATA_W(16), .MEM_AW(8), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .bus(bus), .out(out), .done(done),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .zero_flag(zero_flag), .neg_flag(neg_flag),
`ifdef DATA_PATH_MC_OVF_TRAP_EN
    .ovf_flag(ovf_flag), .trap(trap)
`else
    .ovf_flag(ovf_flag)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] out;
    bit          chk_out;
    logic [2:0]  fl;     // {zero, neg, ovf}
    bit          redir;
    logic [7:0]  tgt;
    bit          trap;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic logic [15:0] enc_r(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] rs2);
    return {3'b000, rs2, rs1, rd, op};
  endfunction
  function automatic logic [15:0] enc_i(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [5:0] imm);
    return {imm, rs1, rd, op};
  endfunction
  function automatic logic [15:0] enc_s(logic [3:0] op, logic [2:0] rd, logic [2:0] rs1, logic [2:0] sh);
    return {sh, 3'b000, rs1, rd, op};
  endfunction

  // memory model
  logic [15:0] tbmem [256];
  bit          auto_mem = 1'b1;
  bit          force_ack = 1'b0;
  int          ack_delay = 0;
  int          req_cnt = 0;
  int          last_req = 0;
  logic [7:0]  exp_maddr = '0;
  logic [15:0] exp_mwd = '0;
  bit          exp_mwe = 1'b0;

  initial begin
    for (int i = 0; i < 256; i++) tbmem[i] = 16'hDEAD;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!auto_mem) begin
        bus.mem_ack = force_ack;
      end else if (bus.mem_req && !bus.mem_ack) begin
        req_cnt++;
        check("mem_we", bus.mem_we, exp_mwe);
        check("mem_addr", bus.mem_addr, exp_maddr);
        if (exp_mwe) check("mem_wdata", bus.mem_wdata, exp_mwd);
        if (req_cnt > ack_delay) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) tbmem[bus.mem_addr] = bus.mem_wdata;
          else            bus.mem_rdata = tbmem[bus.mem_addr];
          last_req = req_cnt;
          req_cnt  = 0;
        end
      end else begin
        bus.mem_ack = 1'b0;
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset && done) begin
      if (q.size() == 0) begin
        check("unexpected_done", done, 1'b0);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "/redir"}, redirect_valid, mon_e.redir);
`ifdef DATA_PATH_MC_OVF_TRAP_EN
        check({mon_e.name, "/trap"}, trap, mon_e.trap);
`endif
        @(negedge clk);
        if (mon_e.chk_out) check({mon_e.name, "/out"}, out, mon_e.out);
        check({mon_e.name, "/flags"}, {zero_flag, neg_flag, ovf_flag}, mon_e.fl);
        if (mon_e.redir) check({mon_e.name, "/tgt"}, redirect_target, mon_e.tgt);
      end
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (!bus.instr_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.instr_ready) check("ready_timeout", bus.instr_ready, 1'b1);
  endtask

  // returns at the falling edge inside the EXEC cycle
  task automatic send_raw(input logic [15:0] ins);
    wait_idle();
    bus.instr       = ins;
    bus.instr_valid = 1'b1;
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  task automatic go(input logic [15:0] ins, input string name, input logic [15:0] eo,
                    input bit co, input logic [2:0] efl, input bit er, input logic [7:0] et,
                    input bit etr);
    exp_t e;
    e.name = name; e.out = eo; e.chk_out = co; e.fl = efl;
    e.redir = er; e.tgt = et; e.trap = etr;
    q.push_back(e);
    send_raw(ins);
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    repeat (3) @(negedge clk);
    check("rst_out", out, 16'h0);
    check("rst_flags", {zero_flag, neg_flag, ovf_flag}, 3'b000);
    check("rst_done", done, 1'b0);
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_redir", {redirect_valid, redirect_target}, 9'h0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", bus.instr_ready, 1'b1);

    go(enc_i(4'd6, 3'd1, 3'd0, 6'd5), "li_r1_5", 16'd5, 1, 3'b000, 0, 0, 0);
    go(enc_r(4'd0, 3'd3, 3'd1, 3'd1), "add_r3", 16'd10, 1, 3'b000, 0, 0, 0);
    check("add_exec_done", done, 1'b0);
    check("add_exec_ready", bus.instr_ready, 1'b0);
    @(negedge clk);
    check("add_wb_done", done, 1'b1);
    @(negedge clk);
    check("add_ready_back", bus.instr_ready, 1'b1);

    ack_delay = 3; exp_maddr = 8'd5; exp_mwd = 16'd10; exp_mwe = 1'b1;
    go(enc_i(4'd8, 3'd3, 3'd0, 6'd5), "sw_r3", 16'd10, 1, 3'b000, 0, 0, 0);
    wait_idle();
    check("sw_req_cycles", last_req, 4);
    ack_delay = 0; exp_mwe = 1'b0;
    go(enc_i(4'd7, 3'd4, 3'd0, 6'd5), "lw_r4", 16'd10, 1, 3'b000, 0, 0, 0);
    wait_idle();
    check("lw_req_cycles", last_req, 1);
    go(enc_r(4'd5, 3'd5, 3'd4, 3'd4), "or_r4", 16'd10, 1, 3'b000, 0, 0, 0);

    go(enc_i(4'd11, 3'd3, 3'd4, 6'h2A), "beq_eq", 16'd0, 1, 3'b000, 1, 8'h2A, 0);
    go(enc_i(4'd11, 3'd3, 3'd1, 6'h2A), "beq_ne", 16'd5, 1, 3'b000, 0, 0, 0);
    go(enc_r(4'd3, 3'd6, 3'd1, 3'd3), "sub_neg", 16'hFFFB, 1, 3'b010, 0, 0, 0);
    go(enc_i(4'd6, 3'd2, 3'd0, 6'h3F), "li_r2_3f", 16'h003F, 1, 3'b000, 0, 0, 0);
    go(enc_s(4'd1, 3'd2, 3'd2, 3'd2), "sll_2", 16'h00FC, 1, 3'b000, 0, 0, 0);
    go(enc_s(4'd2, 3'd7, 3'd2, 3'd3), "srl_3", 16'h001F, 1, 3'b000, 0, 0, 0);
    go(enc_r(4'd4, 3'd6, 3'd6, 3'd2), "and", 16'h00F8, 1, 3'b000, 0, 0, 0);
    go(enc_i(4'd9, 3'd7, 3'd7, 6'h21), "addi", 16'h0040, 1, 3'b000, 0, 0, 0);

    go(enc_i(4'd6, 3'd1, 3'd0, 6'd1), "li_r1_1", 16'h0001, 1, 3'b000, 0, 0, 0);
    go(enc_s(4'd1, 3'd1, 3'd1, 3'd7), "sll_7a", 16'h0080, 1, 3'b000, 0, 0, 0);
    go(enc_s(4'd1, 3'd1, 3'd1, 3'd7), "sll_7b", 16'h4000, 1, 3'b000, 0, 0, 0);
    go(enc_i(4'd6, 3'd2, 3'd0, 6'd1), "li_r2_1", 16'h0001, 1, 3'b000, 0, 0, 0);
    go(enc_r(4'd3, 3'd2, 3'd1, 3'd2), "sub_3fff", 16'h3FFF, 1, 3'b000, 0, 0, 0);
    go(enc_r(4'd0, 3'd1, 3'd1, 3'd2), "add_7fff", 16'h7FFF, 1, 3'b000, 0, 0, 0);
    go(enc_r(4'd0, 3'd2, 3'd1, 3'd1), "add_ovf", 16'hFFFE, 1, 3'b011, 0, 0, TRAP_EN);
    go(enc_r(4'd5, 3'd5, 3'd2, 3'd2), "r2_after_ovf",
       TRAP_EN ? 16'h3FFF : 16'hFFFE, 1, TRAP_EN ? 3'b000 : 3'b010, 0, 0, 0);
    go(enc_r(4'd14, 3'd1, 3'd1, 3'd1), "noop",
       TRAP_EN ? 16'h3FFF : 16'hFFFE, 1, TRAP_EN ? 3'b000 : 3'b010, 0, 0, 0);
    go({3'b000, 9'h1C3, 4'd12}, "jump", 16'h0, 0, TRAP_EN ? 3'b000 : 3'b010, 1, 8'hC3, 0);
    go(enc_i(4'd10, 3'd0, 3'd0, 6'h15), "beqz_r0", 16'h0, 1, TRAP_EN ? 3'b000 : 3'b010, 1, 8'h15, 0);

    // reset in the middle of a load that is never acknowledged
    wait_idle();
    auto_mem = 1'b0; force_ack = 1'b0;
    send_raw(enc_i(4'd7, 3'd1, 3'd0, 6'd5));
    @(negedge clk);
    check("rst_mid_req_on", bus.mem_req, 1'b1);
    #2 reset = 1'b0;
    #1 check("rst_mid_req_drop", bus.mem_req, 1'b0);
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("late_ack_req", bus.mem_req, 1'b0);
      check("late_ack_done", done, 1'b0);
    end
    check("rst_mid_ready", bus.instr_ready, 1'b1);
    check("rst_mid_out", out, 16'h0);
    force_ack = 1'b0;
    @(negedge clk);
    auto_mem = 1'b1;
    for (int k = 0; k < 8; k++)
      go(enc_r(4'd5, 3'd0, 3'(k), 3'(k)), $sformatf("rst_reg%0d", k), 16'h0, 1, 3'b100, 0, 0, 0);

    begin
      int t = 0;
      while (q.size() != 0 && t < 50) begin
        @(negedge clk);
        t++;
      end
      check("queue_drain", q.size(), 0);
    end
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
